// File: rtl/core2wb_pkg.sv
// Shared types and width helpers for the core-to-Wishbone pipelined bridge.
package core2wb_pkg;

    typedef enum logic {StRun, StAbort} state_e;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/core2wb_pipe_if.sv
// Wishbone B4 pipelined bus bundle; master side is the bridge.
interface core2wb_pipe_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [DW/8-1:0] sel;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_o;
    logic [DW-1:0]   dat_i;
    logic            ack;
    logic            err;
    logic            stall;

    modport master (
        output cyc, stb, we, sel, adr, dat_o,
        input  dat_i, ack, err, stall
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_o,
        output dat_i, ack, err, stall
    );
endinterface

// File: rtl/core2wb_watchdog.sv
// Bus watchdog: counts enabled cycles, pulses timeout on the cycle the count reaches Limit.
module core2wb_watchdog #(
    parameter int unsigned Limit = 255,
    parameter int unsigned W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic timeout
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en && (Limit != 0)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    // Fires while the count is being bumped to Limit, so the abort starts the next cycle.
    assign timeout = (Limit != 0) && en && !clr && (cnt_q == W'(Limit - 1));

endmodule

// File: rtl/core2wb_pipe.sv
// Ibex-style req/gnt/rvalid to Wishbone B4 pipelined master with outstanding tracking and watchdog.
// Optional build macro CORE2WB_RESP_REG_EN registers the core response path.
module core2wb_pipe
    import core2wb_pkg::*;
#(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned TimeoutCycles  = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            core_req,
    output logic            core_gnt,
    input  logic            core_we,
    input  logic [DW/8-1:0] core_be,
    input  logic [AW-1:0]   core_addr,
    input  logic [DW-1:0]   core_wdata,
    output logic            core_rvalid,
    output logic [DW-1:0]   core_rdata,
    output logic            core_err,
    core2wb_pipe_if.master  wb,
    output logic            proto_err
);
    localparam int unsigned CntW = cnt_width(MaxOutstanding);
    localparam int unsigned WdW  = cnt_width(TimeoutCycles);

    state_e          state_q, state_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic            proto_err_q;
    logic            bus_resp, busy, can_issue, timeout, spurious;
    logic            stb, cyc, gnt;
    logic            rvalid_c, err_c;
    logic [DW-1:0]   rdata_c;
    logic            wd_en, wd_clr;

    assign bus_resp  = wb.ack | wb.err;
    assign busy      = (outstanding_q != '0);
    assign can_issue = (outstanding_q < CntW'(MaxOutstanding));

    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q;
        stb           = 1'b0;
        cyc           = 1'b0;
        gnt           = 1'b0;
        rvalid_c      = 1'b0;
        err_c         = 1'b0;
        rdata_c       = '0;
        spurious      = 1'b0;
        unique case (state_q)
            StRun: begin
                stb      = core_req & can_issue;
                gnt      = stb & ~wb.stall;
                cyc      = stb | busy;
                rvalid_c = bus_resp & busy;
                err_c    = rvalid_c & wb.err;
                rdata_c  = wb.dat_i;
                spurious = bus_resp & ~busy;
                if (gnt && !rvalid_c) begin
                    outstanding_d = outstanding_q + CntW'(1);
                end else if (!gnt && rvalid_c) begin
                    outstanding_d = outstanding_q - CntW'(1);
                end
                if (timeout) begin
                    state_d = StAbort;
                end
            end
            StAbort: begin
                // Bus is released; each cycle retires one pending transfer as an error.
                rvalid_c      = 1'b1;
                err_c         = 1'b1;
                outstanding_d = outstanding_q - CntW'(1);
                if (outstanding_q == CntW'(1)) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StRun;
            outstanding_q <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            if (spurious) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    assign wd_en  = (state_q == StRun) & busy;
    assign wd_clr = ~wd_en | bus_resp;

    core2wb_watchdog #(
        .Limit (TimeoutCycles),
        .W     (WdW)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .en      (wd_en),
        .clr     (wd_clr),
        .timeout (timeout)
    );

    assign wb.cyc   = cyc;
    assign wb.stb   = stb;
    assign wb.we    = core_we;
    assign wb.sel   = core_be;
    assign wb.adr   = core_addr;
    assign wb.dat_o = core_wdata;
    assign core_gnt = gnt;
    assign proto_err = proto_err_q;

`ifdef CORE2WB_RESP_REG_EN
    logic          rvalid_q, err_q;
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_c;
            err_q    <= err_c;
            rdata_q  <= rdata_c;
        end
    end

    assign core_rvalid = rvalid_q;
    assign core_err    = err_q;
    assign core_rdata  = rdata_q;
`else
    assign core_rvalid = rvalid_c;
    assign core_err    = err_c;
    assign core_rdata  = rdata_c;
`endif

endmodule
